// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
//
// Turns four debounced direction-key levels into single move commands for the
// maze position datapath. Each move is offered on a valid/ready handshake.
// Simultaneous new presses are resolved by fixed priority
// (up > down > left > right). A held key produces timed auto-repeat moves.
//
// Ports:
//   clk          system clock, rising edge
//   nrst         asynchronous active-low reset
//   key_up       debounced level, 1 = pressed
//   key_down     debounced level, 1 = pressed
//   key_left     debounced level, 1 = pressed
//   key_right    debounced level, 1 = pressed
//   enable       game running; new moves start only while high
//   repeat_en    enables auto-repeat while a key is held
//   move_ready   datapath accepts the pending move this cycle
//   move_valid   a move command is pending
//   move_dir     00 up, 01 down, 10 left, 11 right
// -----------------------------------------------------------------------------
module move_scheduler #(
  parameter int REPEAT_DELAY = 25000,
  parameter int REPEAT_RATE  = 10000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       enable,
  input  logic       repeat_en,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // The counter counts down to zero, so it is loaded with delay-1.
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

  state_t           state_q, state_d;
  logic [1:0]       dir_q,   dir_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             first_q, first_d;
  logic [3:0]       hist_q,  hist_d;

  // Bit index equals the direction code, so priority is lowest index first.
  logic [3:0] keys;
  logic [3:0] new_press;
  logic [3:0] other_press;
  logic       key_held;

  assign keys        = {key_right, key_left, key_down, key_up};
  assign new_press   = keys & ~hist_q;
  assign other_press = new_press & ~(4'b0001 << dir_q);
  assign key_held    = keys[dir_q];

  function automatic logic [1:0] pick_dir(input logic [3:0] presses);
    if (presses[0])      return 2'd0;
    else if (presses[1]) return 2'd1;
    else if (presses[2]) return 2'd2;
    else                 return 2'd3;
  endfunction

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      dir_q   <= 2'd0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      // Keys already held at reset must be released before they can move.
      hist_q  <= 4'b1111;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      hist_q  <= hist_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal written here is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    hist_d  = keys;

    unique case (state_q)
      IDLE: begin
        if (enable && (|new_press)) begin
          dir_d   = pick_dir(new_press);
          first_d = 1'b1;
          state_d = ISSUE;
        end
      end

      // The command is never withdrawn; presses arriving here are dropped.
      ISSUE: begin
        if (move_ready) begin
          cnt_d   = first_q ? DELAY_LOAD : RATE_LOAD;
          first_d = 1'b0;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (!enable || !key_held) begin
          state_d = IDLE;
        end else if (|other_press) begin
          // Preemptive switch to a freshly pressed different key.
          dir_d   = pick_dir(other_press);
          first_d = 1'b1;
          state_d = ISSUE;
        end else if (repeat_en) begin
          if (cnt_q == '0) begin
            first_d = 1'b0;
            state_d = ISSUE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    move_valid = (state_q == ISSUE);
    move_dir   = dir_q;
  end

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_move_scheduler
//
// Table-driven bench for move_scheduler with REPEAT_DELAY=5, REPEAT_RATE=3.
// Each table row holds the inputs applied for one clock cycle and the outputs
// expected just after the following rising edge. Reset behaviour is covered
// by hand-written sequences around the table.
// -----------------------------------------------------------------------------
module tb_move_scheduler;

  typedef struct {
    logic [3:0] keys;   // {right, left, down, up}
    logic       en;
    logic       rep;
    logic       rdy;
    logic       exp_v;
    logic [1:0] exp_d;
  } vec_t;

  logic       clk = 1'b0;
  logic       nrst;
  logic       key_up, key_down, key_left, key_right;
  logic       enable, repeat_en, move_ready;
  logic       move_valid;
  logic [1:0] move_dir;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  move_scheduler #(
    .REPEAT_DELAY(5),
    .REPEAT_RATE (3),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .enable    (enable),
    .repeat_en (repeat_en),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_dir  (move_dir)
  );

  task automatic check(input string name, input logic [1:0] actual,
                       input logic [1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic drive(input logic [3:0] k, input logic en, input logic rep,
                       input logic rdy);
    key_up     = k[0];
    key_down   = k[1];
    key_left   = k[2];
    key_right  = k[3];
    enable     = en;
    repeat_en  = rep;
    move_ready = rdy;
  endtask

  // Drive inputs for one cycle, then sample 1 time unit after the edge.
  task automatic step(input logic [3:0] k, input logic en, input logic rep,
                      input logic rdy);
    drive(k, en, rep, rdy);
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [3:0] k, input logic en,
                              input logic rep, input logic rdy,
                              input logic ev, input logic [1:0] ed);
    vec_t v;
    v.keys  = k;
    v.en    = en;
    v.rep   = rep;
    v.rdy   = rdy;
    v.exp_v = ev;
    v.exp_d = ed;
    vecs.push_back(v);
  endfunction

  initial begin
    // ---- Tap key_left, repeat off: one move, 1 cycle after rise ----
    add(4'b0000, 1, 0, 1, 0, 2'b00);
    add(4'b0100, 1, 0, 1, 1, 2'b10);
    add(4'b0100, 1, 0, 1, 0, 2'b10);
    add(4'b0100, 1, 0, 1, 0, 2'b10);
    add(4'b0000, 1, 0, 1, 0, 2'b10);
    add(4'b0000, 1, 0, 1, 0, 2'b10);
    // ---- up+right together -> up; then down while up held -> down ----
    add(4'b1001, 1, 0, 1, 1, 2'b00);
    add(4'b1001, 1, 0, 1, 0, 2'b00);
    add(4'b1001, 1, 0, 1, 0, 2'b00);
    add(4'b1011, 1, 0, 1, 1, 2'b01);
    add(4'b1011, 1, 0, 1, 0, 2'b01);
    add(4'b1011, 1, 0, 1, 0, 2'b01);
    add(4'b0000, 1, 0, 1, 0, 2'b01);
    add(4'b0000, 1, 0, 1, 0, 2'b01);
    // ---- Hold key_down 20 cycles with repeat: transfers t,+6,+10,+14,+18 ----
    for (int i = 0; i < 20; i++) begin
      add(4'b0010, 1, 1, 1, (i == 0 || i == 6 || i == 10 || i == 14 || i == 18),
          2'b01);
    end
    add(4'b0000, 1, 1, 1, 0, 2'b01);
    add(4'b0000, 1, 1, 1, 0, 2'b01);
    add(4'b0000, 1, 1, 1, 0, 2'b01);
    // ---- Backpressure on key_right, key released meanwhile ----
    add(4'b1000, 1, 1, 0, 1, 2'b11);
    add(4'b1000, 1, 1, 0, 1, 2'b11);
    add(4'b0000, 1, 1, 0, 1, 2'b11);
    add(4'b0000, 1, 1, 0, 1, 2'b11);
    add(4'b0000, 1, 1, 1, 0, 2'b11);
    add(4'b0000, 1, 1, 1, 0, 2'b11);
    add(4'b0000, 1, 1, 1, 0, 2'b11);
    // ---- enable=0 blocks a press; the press is not queued ----
    add(4'b0100, 0, 0, 1, 0, 2'b11);
    add(4'b0100, 0, 0, 1, 0, 2'b11);
    add(4'b0100, 1, 0, 1, 0, 2'b11);
    add(4'b0000, 1, 0, 1, 0, 2'b11);
    // ---- Drop enable during ISSUE: command still completes, back to IDLE ----
    add(4'b0001, 1, 1, 0, 1, 2'b00);
    add(4'b0001, 0, 1, 0, 1, 2'b00);
    add(4'b0001, 0, 1, 0, 1, 2'b00);
    add(4'b0001, 0, 1, 1, 0, 2'b00);
    add(4'b0001, 0, 1, 1, 0, 2'b00);
    // Key still held and enable back: IDLE must not repeat (HOLD would)
    for (int i = 0; i < 7; i++) add(4'b0001, 1, 1, 1, 0, 2'b00);
    add(4'b0000, 1, 0, 1, 0, 2'b00);

    // ---- Reset state ----
    nrst = 1'b0;
    drive(4'b0000, 1, 0, 1);
    #2;
    check("reset_valid", {1'b0, move_valid}, 2'b00);
    check("reset_dir", move_dir, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;

    // ---- Table ----
    foreach (vecs[i]) begin
      step(vecs[i].keys, vecs[i].en, vecs[i].rep, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), {1'b0, move_valid}, {1'b0, vecs[i].exp_v});
      check($sformatf("vec%0d_dir", i), move_dir, vecs[i].exp_d);
    end

    // ---- Reset mid-ISSUE clears outputs immediately ----
    step(4'b0100, 1, 0, 0);
    check("pre_rst_valid", {1'b0, move_valid}, 2'b01);
    check("pre_rst_dir", move_dir, 2'b10);
    drive(4'b0001, 1, 0, 1);
    nrst = 1'b0;
    #2;
    check("async_rst_valid", {1'b0, move_valid}, 2'b00);
    check("async_rst_dir", move_dir, 2'b00);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // ---- key_up held through reset: no move until released and re-pressed ----
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 1, 0, 1);
      check($sformatf("held_rst%0d_valid", i), {1'b0, move_valid}, 2'b00);
    end
    step(4'b0000, 1, 0, 1);
    check("release_valid", {1'b0, move_valid}, 2'b00);
    step(4'b0001, 1, 0, 1);
    check("repress_valid", {1'b0, move_valid}, 2'b01);
    check("repress_dir", move_dir, 2'b00);
    step(4'b0001, 1, 0, 1);
    check("repress_done", {1'b0, move_valid}, 2'b00);
    step(4'b0000, 1, 0, 1);
    check("final_idle", {1'b0, move_valid}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
Converts four debounced direction-key levels into single move commands for the maze position datapath. Each move is sent over a valid/ready handshake. Simultaneous presses are resolved by fixed priority, and a held key produces timed auto-repeat moves. The block sits between the four debounce instances and the player-position update logic.

Parameters:
REPEAT_DELAY, 25000, cycles from the accepted first move to the first auto-repeat issue (must be >= 1).
REPEAT_RATE, 10000, cycles between later auto-repeat issues (must be >= 1).
CNT_W, 16, repeat counter width; both delays must fit in CNT_W bits.

Ports:
clk  input  1  system clock, rising-edge.
nrst  input  1  asynchronous active-low reset.
key_up  input  1  debounced level, 1 = pressed.
key_down  input  1  debounced level, 1 = pressed.
key_left  input  1  debounced level, 1 = pressed.
key_right  input  1  debounced level, 1 = pressed.
enable  input  1  game running; new moves are started only while high.
repeat_en  input  1  enables auto-repeat while a key is held.
move_ready  input  1  datapath accepts the move this cycle.
move_valid  output  1  a move command is pending.
move_dir  output  2  direction: 00 up, 01 down, 10 left, 11 right.

Behaviour:
- Reset (async, nrst=0):
  - state=IDLE, move_valid=0, move_dir=00, counter=0, first-flag=1.
  - key history register = 4'b1111, so keys already held at reset never generate a move until released and pressed again.
- Edge detect:
  - key history is registered every cycle.
  - new_press[i] = key[i] & ~hist[i].
  - Priority among simultaneous new presses: up > down > left > right.
- IDLE:
  - if enable=1 and any new_press: latch the highest-priority direction into move_dir, go to ISSUE, set first-flag=1.
  - Latency: move_valid rises on the clock edge where the key is first sampled high, i.e. 1 cycle after the input change.
- ISSUE:
  - move_valid=1; move_dir is held stable.
  - The command is never withdrawn: key release and enable=0 do not cancel it.
  - on move_ready=1: transfer completes; move_valid=0 next cycle; go to HOLD.
  - On transfer, counter loads REPEAT_DELAY-1 if first-flag=1, else REPEAT_RATE-1; first-flag is then cleared.
  - new_press events arriving during ISSUE are discarded.
- HOLD (evaluated in this order):
  - enable=0 or latched key released -> IDLE.
  - any new_press on a key other than the latched one -> latch the new direction (priority rule applies), first-flag=1, go to ISSUE. This is a preemptive direction switch.
  - repeat_en=1 and counter==0 -> ISSUE with first-flag=0.
  - otherwise counter decrements when repeat_en=1 and holds when repeat_en=0.
- Throughput limit: at most one transfer per 2 cycles, because ISSUE->HOLD->ISSUE takes at least 2 cycles.
- Repeat timing: with move_ready tied high and the key held, transfers occur at cycle t, t+REPEAT_DELAY+1, and then every REPEAT_RATE+1 cycles.
- Counter never underflows; it is only decremented when non-zero.
- Reset mid-operation: outputs return to reset values immediately. A pending command is lost; this is the datapath's responsibility.

Test Plan:
- Bench parameters: REPEAT_DELAY=5, REPEAT_RATE=3, move_ready=1, enable=1, repeat_en=0. Tap key_left for 3 cycles -> exactly one cycle of move_valid=1 with move_dir=10, 1 cycle after key_left rises; no further moves.
- Raise key_up and key_right in the same cycle -> one move with move_dir=00. Then raise key_down while key_up is held -> one move with move_dir=01. key_right never issues.
- Hold key_down with repeat_en=1 for 20 cycles -> transfers at t, t+6, t+10, t+14, t+18, all with move_dir=01. Releasing the key stops further moves.
- Backpressure: hold move_ready=0 for 4 cycles after key_right press, and release the key meanwhile -> move_valid=1 with move_dir=11 held stable for 4 cycles; transfer occurs on the cycle ready rises; no repeat follows.
- Assert nrst while key_up is held, then deassert -> no move; release and press again -> one move with move_dir=00.
- With enable=0, press key_left -> no move_valid. Drop enable during ISSUE with ready=0 -> the command still completes when ready=1, then the FSM returns to IDLE.
